// File: rtl/mem_handshake_responder_pkg.sv
// Shared encodings for the MOC memory handshake.
// Used by the responder, the lane aligner and the CPU control unit.
package mem_pkg;

  // Access size as driven on the size strobe; 2'b11 is reserved and treated as word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } memSize_e;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_DONE
  } memState_e;

  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/mem_handshake_responder_if.sv
// MOC handshake bus between the CPU (master) and the memory responder (slave).
//   mem_enable/rw/size/unsign/address/data_in : request, driven by the CPU
//   data_out/moc/misaligned                    : response, driven by memory
interface mem_handshake_responder_if;
  logic        mem_enable;
  logic        rw;
  logic [1:0]  size;
  logic        unsign;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        misaligned;

  modport master (
    output mem_enable, rw, size, unsign, address, data_in,
    input  data_out, moc, misaligned
  );

  modport slave (
    input  mem_enable, rw, size, unsign, address, data_in,
    output data_out, moc, misaligned
  );
endinterface

// File: rtl/mem_handshake_responder_lane_align.sv
// Combinational read-lane aligner.
//   size       : access size (mem_pkg encoding)
//   addrLow    : address bits [1:0]
//   unsign     : 1 = zero-extend, 0 = sign-extend sub-word reads
//   fetched    : bytes at A, A+1, A+2, A+3 packed big-endian (A in [31:24])
//   rdData     : extended read word, 0 when misaligned
//   misaligned : request not aligned to its size
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLow,
  input  logic        unsign,
  input  logic [31:0] fetched,
  output logic [31:0] rdData,
  output logic        misaligned
);

  always_comb begin
    rdData     = '0;
    misaligned = ((size == SZ_HALF) && addrLow[0]) ||
                 (size[1] && (addrLow != 2'b00));
    if (!misaligned) begin
      case (size)
        SZ_BYTE: rdData = unsign ? {24'h0, fetched[31:24]}
                                 : {{24{fetched[31]}}, fetched[31:24]};
        SZ_HALF: rdData = unsign ? {16'h0, fetched[31:16]}
                                 : {{16{fetched[31]}}, fetched[31:16]};
        default: rdData = fetched;
      endcase
    end
  end

endmodule

// File: rtl/mem_handshake_responder.sv
// Memory-side responder for the MOC handshake: latches a request, waits
// WAIT_CYCLES, performs a big-endian access on an internal byte array and
// raises moc until the request strobe is released.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; array contents are not reset
//   bus   : MOC handshake bus (slave side)
module mem_handshake_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  mem_handshake_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  logic [7:0]    memArray [DEPTH_BYTES];

  memState_e     state, stateNext;
  logic          reqRw;
  logic [1:0]    reqSize;
  logic          reqUnsign;
  logic [AW-1:0] reqAddr;
  logic [31:0]   reqData;
  logic [3:0]    waitCnt;

  logic [AW-1:0] laneAddr [4];
  logic [31:0]   fetched;
  logic [31:0]   alignedRd;
  logic          alignMis;
  logic          accept;
  logic          complete;
  logic          commitWrite;

  // Lane addresses are AW bits wide, so the +1..+3 lanes wrap for free.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      laneAddr[i] = reqAddr + AW'(i);
    end
    fetched = {memArray[laneAddr[0]], memArray[laneAddr[1]],
               memArray[laneAddr[2]], memArray[laneAddr[3]]};
  end

  mem_lane_align uAlign (
    .size       (reqSize),
    .addrLow    (reqAddr[1:0]),
    .unsign     (reqUnsign),
    .fetched    (fetched),
    .rdData     (alignedRd),
    .misaligned (alignMis)
  );

  // Abort (enable dropped) is tested before counter expiry so it wins.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (bus.mem_enable) begin
          accept    = 1'b1;
          stateNext = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        if (!bus.mem_enable) begin
          stateNext = MEM_IDLE;
        end else if (waitCnt == 4'd0) begin
          complete  = 1'b1;
          stateNext = MEM_DONE;
        end
      end
      MEM_DONE: begin
        if (!bus.mem_enable) stateNext = MEM_IDLE;
      end
      default: stateNext = MEM_IDLE;
    endcase
    commitWrite = complete && (reqRw != RW_READ) && !alignMis;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MEM_IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqRw          <= 1'b0;
      reqSize        <= '0;
      reqUnsign      <= 1'b0;
      reqAddr        <= '0;
      reqData        <= '0;
      waitCnt        <= '0;
      bus.moc        <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.data_out   <= '0;
    end else begin
      if (accept) begin
        reqRw     <= bus.rw;
        reqSize   <= bus.size;
        reqUnsign <= bus.unsign;
        reqAddr   <= bus.address[AW-1:0];
        reqData   <= bus.data_in;
        waitCnt   <= 4'(WAIT_CYCLES);
      end
      if ((state == MEM_BUSY) && bus.mem_enable && (waitCnt != 4'd0)) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (complete) begin
        bus.moc        <= 1'b1;
        bus.misaligned <= alignMis;
        bus.data_out   <= alignedRd;
      end
      if ((state == MEM_DONE) && !bus.mem_enable) begin
        bus.moc        <= 1'b0;
        bus.misaligned <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commitWrite) begin
      case (reqSize)
        SZ_BYTE: memArray[laneAddr[0]] <= reqData[7:0];
        SZ_HALF: begin
          memArray[laneAddr[0]] <= reqData[15:8];
          memArray[laneAddr[1]] <= reqData[7:0];
        end
        default: begin
          memArray[laneAddr[0]] <= reqData[31:24];
          memArray[laneAddr[1]] <= reqData[23:16];
          memArray[laneAddr[2]] <= reqData[15:8];
          memArray[laneAddr[3]] <= reqData[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handshake_responder.sv
module tb_mem_handshake_responder;
  import mem_pkg::*;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned WAITC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_handshake_responder_if memBus();

  mem_handshake_responder #(
    .DEPTH_BYTES (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (memBus)
  );

  logic [7:0] refMem [DEPTH];
  int compareCount  = 0;
  int mismatchCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sizeBytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit refMisaligned(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd1 && (a % 2) != 0) || (s >= 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a, input logic [1:0] s, input logic uns);
    longint unsigned v = 0;
    int unsigned n = sizeBytes(s);
    int unsigned idx = a % DEPTH;
    for (int unsigned i = 0; i < n; i++) v = v * 256 + refMem[(idx + i) % DEPTH];
    if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic refWrite(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int unsigned n = sizeBytes(s);
    int unsigned idx = a % DEPTH;
    for (int unsigned i = 0; i < n; i++)
      refMem[(idx + i) % DEPTH] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
  endtask

  task automatic scramble();
    memBus.rw      = 1'($urandom);
    memBus.size    = 2'($urandom);
    memBus.unsign  = 1'($urandom);
    memBus.address = $urandom;
    memBus.data_in = $urandom;
  endtask

  // Full four-phase transaction; live inputs are scrambled while busy.
  task automatic doAccess(input logic rwIn, input logic [1:0] s, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          input int unsigned hold, output logic [31:0] rd);
    bit expMis = refMisaligned(a, s);
    bit checkData = (rwIn == RW_READ) || expMis;
    logic [31:0] expData = expMis ? 32'h0 : refRead(a, s, uns);
    int edges = 0;
    @(negedge clk);
    memBus.mem_enable = 1'b1;
    memBus.rw = rwIn; memBus.size = s; memBus.unsign = uns;
    memBus.address = a; memBus.data_in = d;
    @(posedge clk);
    while (edges < 40) begin
      @(negedge clk); scramble();
      @(posedge clk); #1;
      edges++;
      if (memBus.moc) break;
    end
    checkVal("latency", 32'(edges), 32'(WAITC + 1));
    checkVal("moc_rise", 32'(memBus.moc), 32'd1);
    checkVal("misaligned", 32'(memBus.misaligned), 32'(expMis));
    if (checkData) checkVal("data_out", memBus.data_out, expData);
    if (!expMis && rwIn != RW_READ) refWrite(a, s, d);
    for (int unsigned k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checkVal("hold_moc", 32'(memBus.moc), 32'd1);
      if (checkData) checkVal("hold_data", memBus.data_out, expData);
    end
    rd = memBus.data_out;
    @(negedge clk); memBus.mem_enable = 1'b0;
    @(posedge clk); #1;
    checkVal("moc_fall", 32'(memBus.moc), 32'd0);
    checkVal("mis_fall", 32'(memBus.misaligned), 32'd0);
    if (checkData) checkVal("data_kept", memBus.data_out, expData);
  endtask

  // Start a write and drop enable so it is sampled low at edge N+dropEdge.
  task automatic abortWrite(input logic [31:0] a, input logic [31:0] d, input int unsigned dropEdge);
    @(negedge clk);
    memBus.mem_enable = 1'b1; memBus.rw = 1'b0; memBus.size = SZ_WORD;
    memBus.unsign = 1'b0; memBus.address = a; memBus.data_in = d;
    @(posedge clk);
    repeat (dropEdge - 1) @(posedge clk);
    @(negedge clk); memBus.mem_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkVal("abort_moc", 32'(memBus.moc), 32'd0);
    end
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b1;
    memBus.mem_enable = 1'b0; memBus.rw = 1'b0; memBus.size = '0;
    memBus.unsign = 1'b0; memBus.address = '0; memBus.data_in = '0;
    #1;
    checkVal("rst_moc", 32'(memBus.moc), 32'd0);
    checkVal("rst_mis", 32'(memBus.misaligned), 32'd0);
    checkVal("rst_data", memBus.data_out, 32'd0);
    checkVal("rst_state", 32'(dut.state), 32'(MEM_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int unsigned i = 0; i < DEPTH / 4; i++)
      doAccess(1'b0, SZ_WORD, 1'b0, 32'(i * 4), $urandom, 0, rd);

    doAccess(1'b0, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd);
    doAccess(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, rd);
    checkVal("word_rt", rd, 32'hDEADBEEF);
    doAccess(1'b1, SZ_BYTE, 1'b1, 32'h10, 32'h0, 0, rd); checkVal("byte10", rd, 32'hDE);
    doAccess(1'b1, SZ_BYTE, 1'b1, 32'h11, 32'h0, 0, rd); checkVal("byte11", rd, 32'hAD);
    doAccess(1'b1, SZ_BYTE, 1'b1, 32'h13, 32'h0, 0, rd); checkVal("byte13", rd, 32'hEF);
    doAccess(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0, 0, rd); checkVal("byte_sext", rd, 32'hFFFFFFBE);
    doAccess(1'b1, SZ_BYTE, 1'b1, 32'h12, 32'h0, 0, rd); checkVal("byte_zext", rd, 32'h000000BE);

    doAccess(1'b0, SZ_HALF, 1'b0, 32'h12, 32'hFFFF1234, 0, rd);
    doAccess(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, rd); checkVal("half_wr", rd, 32'hDEAD1234);

    doAccess(1'b0, SZ_WORD, 1'b0, 32'h11, 32'h11111111, 0, rd);
    doAccess(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, rd); checkVal("mis_nowr", rd, 32'hDEAD1234);

    abortWrite(32'h10, 32'h55AA55AA, 2);
    abortWrite(32'h10, 32'h66666666, WAITC + 1);
    doAccess(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, rd); checkVal("abort_mem", rd, 32'hDEAD1234);

    @(negedge clk);
    memBus.mem_enable = 1'b1; memBus.rw = 1'b0; memBus.size = SZ_WORD;
    memBus.address = 32'h10; memBus.data_in = 32'h0BADF00D;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkVal("arst_moc", 32'(memBus.moc), 32'd0);
    checkVal("arst_data", memBus.data_out, 32'd0);
    checkVal("arst_state", 32'(dut.state), 32'(MEM_IDLE));
    @(negedge clk); memBus.mem_enable = 1'b0;
    @(negedge clk); reset = 1'b0;
    doAccess(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, rd); checkVal("arst_mem", rd, 32'hDEAD1234);

    doAccess(1'b0, SZ_WORD, 1'b0, 32'h200, 32'hCAFEF00D, 0, rd);
    doAccess(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0, 5, rd); checkVal("wrap", rd, 32'hCAFEF00D);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      doAccess(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
               $urandom_range(0, 3), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
